clk_period_monitor: RTL and testbench

//  Consumer side of our clock dividers. Samples a slow divided clock (for example,
//  the 10 kHz enable clock) in the clk_50MHz domain and synchronizes it. Emits a
//  one-cycle tick for each of its rising edges and measures its period in
//  clk_50MHz cycles. Flags an off-nominal or lost input clock. Sits between the

---
 rtl/clk_period_monitor_if.sv | 22 ++
 rtl/clk_period_monitor.sv | 128 ++++++++++++
 tb/tb_clk_period_monitor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_period_monitor_if.sv
// Bus between the clock period monitor and the logic consuming its ticks.
// The monitor side takes the master modport; the consumer or stimulus side takes the slave modport.
interface clk_period_monitor_if #(
  parameter int CNT_W = 16
);
  logic             clk_in;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             in_range;
  logic             lost;

  modport master (
    input  clk_in,
    output tick, period, period_valid, in_range, lost
  );

  modport slave (
    output clk_in,
    input  tick, period, period_valid, in_range, lost
  );
endinterface

// File: rtl/clk_period_monitor.sv
// Synchronizes a slow divided clock into clk_50MHz, emits a tick per rising edge,
// measures its period in system cycles and flags off-nominal or lost input.
module clk_period_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int NOMINAL     = 5002,
  parameter int TOL         = 16,
  parameter int TIMEOUT     = 12000
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  clk_period_monitor_if.master mon
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  localparam logic [CNT_W:0]   NOMINAL_C = (CNT_W+1)'(NOMINAL);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   tick_q, tick_d;
  logic                   valid_q, valid_d;
  logic                   in_range_q, in_range_d;
  logic                   lost_q, lost_d;

  logic                   rise_s;
  logic [CNT_W:0]         count_ext_s;
  logic [CNT_W:0]         diff_s;
  logic                   in_tol_s;

  assign rise_s      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign count_ext_s = {1'b0, count_q};
  assign diff_s      = (count_ext_s >= NOMINAL_C) ? (count_ext_s - NOMINAL_C)
                                                  : (NOMINAL_C - count_ext_s);
  assign in_tol_s    = (diff_s <= TOL_C);

  // Next-state logic for the synchronizer, edge detector and measurement FSM.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], mon.clk_in};
    prev_d     = sync_q[SYNC_STAGES-1];
    tick_d     = rise_s;
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    in_range_d = in_range_q;
    lost_d     = lost_q;
    case (state_q)
      ACQUIRE: begin
        if (rise_s) begin
          state_d = MEASURE;
          count_d = CNT_W'(1);
        end else begin
          count_d = '0;
        end
      end
      MEASURE: begin
        // A rise landing on the timeout cycle still counts as a valid period.
        if (rise_s) begin
          period_d   = count_q;
          valid_d    = 1'b1;
          count_d    = CNT_W'(1);
          in_range_d = in_tol_s;
        end else if (count_q == TIMEOUT_C) begin
          state_d    = LOST;
          lost_d     = 1'b1;
          in_range_d = 1'b0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      LOST: begin
        if (rise_s) begin
          state_d = MEASURE;
          count_d = CNT_W'(1);
          lost_d  = 1'b0;
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = ACQUIRE;
        count_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q    <= ACQUIRE;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      count_q    <= '0;
      period_q   <= '0;
      tick_q     <= 1'b0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      count_q    <= count_d;
      period_q   <= period_d;
      tick_q     <= tick_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      lost_q     <= lost_d;
    end
  end

  assign mon.tick         = tick_q;
  assign mon.period       = period_q;
  assign mon.period_valid = valid_q;
  assign mon.in_range     = in_range_q;
  assign mon.lost         = lost_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: drives clk_in at a fixed phase and
// checks ticks, periods, range and lost flags against hand-computed values.
module tb_clk_period_monitor;

  logic clk_50MHz;
  logic reset;
  int   vec;
  int   miss;

  int   cyc;
  int   tick_cnt;
  int   pv_cnt;
  int   lost_cnt;
  int   last_tick_cyc;
  int   prev_tick_cyc;
  logic [15:0] last_period;
  logic        last_in_range;

  int   t0;
  int   p0;

  clk_period_monitor_if #(.CNT_W(16)) bus ();

  clk_period_monitor dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .mon       (bus)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  // Records output events at the falling edge, away from the active edge.
  always @(negedge clk_50MHz) begin
    if (bus.tick) begin
      prev_tick_cyc = last_tick_cyc;
      last_tick_cyc = cyc;
      tick_cnt      = tick_cnt + 1;
    end
    if (bus.period_valid) begin
      pv_cnt        = pv_cnt + 1;
      last_period   = bus.period;
      last_in_range = bus.in_range;
    end
    if (bus.lost) lost_cnt = lost_cnt + 1;
  end

  // Hold clk_in at a level for n cycles; always returns 5 ns after a rising edge.
  task automatic drive_level(input logic l, input int n);
    bus.clk_in = l;
    repeat (n) begin
      @(posedge clk_50MHz);
      #5;
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.clk_in = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    #1;
    vec++; if (bus.tick !== 1'b0) begin miss++; $display("FAIL reset_tick: got %b expected 0", bus.tick); end
    vec++; if (bus.period !== 16'd0) begin miss++; $display("FAIL reset_period: got %0d expected 0", bus.period); end
    vec++; if (bus.period_valid !== 1'b0) begin miss++; $display("FAIL reset_valid: got %b expected 0", bus.period_valid); end
    vec++; if (bus.in_range !== 1'b0) begin miss++; $display("FAIL reset_in_range: got %b expected 0", bus.in_range); end
    vec++; if (bus.lost !== 1'b0) begin miss++; $display("FAIL reset_lost: got %b expected 0", bus.lost); end
    #4;
    reset = 1'b0;
    drive_level(1'b0, 5);
  endtask

  task automatic test_latency;
    logic exp_tick [4];
    exp_tick[0] = 1'b0; exp_tick[1] = 1'b0; exp_tick[2] = 1'b1; exp_tick[3] = 1'b0;
    bus.clk_in = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk_50MHz);
      #1;
      vec++;
      if (bus.tick !== exp_tick[e]) begin
        miss++;
        $display("FAIL latency_tick_edge%0d: got %b expected %b", e + 1, bus.tick, exp_tick[e]);
      end
    end
    #4;
    drive_level(1'b1, 2497);
    drive_level(1'b0, 2501);
    vec++; if (pv_cnt !== 0) begin miss++; $display("FAIL first_rise_valid: got %0d pulses expected 0", pv_cnt); end
    vec++; if (tick_cnt !== 1) begin miss++; $display("FAIL first_rise_ticks: got %0d expected 1", tick_cnt); end
  endtask

  task automatic test_nominal;
    drive_level(1'b1, 10);
    vec++; if (pv_cnt !== 1) begin miss++; $display("FAIL nominal_valid_cnt: got %0d expected 1", pv_cnt); end
    vec++; if (last_period !== 16'd5002) begin miss++; $display("FAIL nominal_period: got %0d expected 5002", last_period); end
    chk1("nominal_in_range", last_in_range, 1'b1);
    vec++; if (last_tick_cyc - prev_tick_cyc !== 5002) begin miss++; $display("FAIL nominal_tick_spacing: got %0d expected 5002", last_tick_cyc - prev_tick_cyc); end
    drive_level(1'b1, 2491);
    drive_level(1'b0, 2501);
    drive_level(1'b1, 10);
  endtask

  // Each entry: high cycles after the 10 already spent high, low cycles, expected period, in_range.
  task automatic test_off_nominal;
    int hi [4];
    int lo [4];
    int pe [4];
    logic ir [4];
    hi[0] = 2505; lo[0] = 2515; pe[0] = 5030; ir[0] = 1'b0;
    hi[1] = 2499; lo[1] = 2509; pe[1] = 5018; ir[1] = 1'b1;
    hi[2] = 2489; lo[2] = 2486; pe[2] = 4985; ir[2] = 1'b0;
    hi[3] = 2490; lo[3] = 2486; pe[3] = 4986; ir[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p0 = pv_cnt;
      drive_level(1'b1, hi[k]);
      drive_level(1'b0, lo[k]);
      drive_level(1'b1, 10);
      vec++; if (pv_cnt !== p0 + 1) begin miss++; $display("FAIL off_nom%0d_valid: got %0d pulses expected 1", k, pv_cnt - p0); end
      vec++; if (last_period !== 16'(pe[k])) begin miss++; $display("FAIL off_nom%0d_period: got %0d expected %0d", k, last_period, pe[k]); end
      vec++; if (last_in_range !== ir[k]) begin miss++; $display("FAIL off_nom%0d_in_range: got %b expected %b", k, last_in_range, ir[k]); end
    end
  endtask

  task automatic test_lost;
    drive_level(1'b1, 2491);
    drive_level(1'b0, 9489);
    chk1("lost_before_timeout", bus.lost, 1'b0);
    drive_level(1'b0, 30);
    chk1("lost_after_timeout", bus.lost, 1'b1);
    chk1("lost_clears_in_range", bus.in_range, 1'b0);
    vec++; if (bus.period !== 16'd4986) begin miss++; $display("FAIL lost_keeps_period: got %0d expected 4986", bus.period); end
    p0 = pv_cnt;
    t0 = tick_cnt;
    drive_level(1'b1, 10);
    chk1("lost_restart_clear", bus.lost, 1'b0);
    vec++; if (pv_cnt !== p0) begin miss++; $display("FAIL lost_restart_valid: got %0d pulses expected 0", pv_cnt - p0); end
    vec++; if (tick_cnt !== t0 + 1) begin miss++; $display("FAIL lost_restart_tick: got %0d ticks expected 1", tick_cnt - t0); end
    drive_level(1'b1, 2491);
    drive_level(1'b0, 2501);
    drive_level(1'b1, 10);
    vec++; if (pv_cnt !== p0 + 1) begin miss++; $display("FAIL after_lost_valid: got %0d pulses expected 1", pv_cnt - p0); end
    vec++; if (last_period !== 16'd5002) begin miss++; $display("FAIL after_lost_period: got %0d expected 5002", last_period); end
  endtask

  task automatic test_timeout_race;
    p0 = pv_cnt;
    t0 = lost_cnt;
    drive_level(1'b1, 2490);
    drive_level(1'b0, 9500);
    drive_level(1'b1, 10);
    vec++; if (pv_cnt !== p0 + 1) begin miss++; $display("FAIL race_valid: got %0d pulses expected 1", pv_cnt - p0); end
    vec++; if (last_period !== 16'd12000) begin miss++; $display("FAIL race_period: got %0d expected 12000", last_period); end
    vec++; if (lost_cnt !== t0) begin miss++; $display("FAIL race_lost: got %0d lost cycles expected 0", lost_cnt - t0); end
  endtask

  task automatic test_reset_high_clk;
    drive_level(1'b1, 100);
    reset = 1'b1;
    #1;
    vec++; if (bus.period !== 16'd0) begin miss++; $display("FAIL midreset_period: got %0d expected 0", bus.period); end
    repeat (3) @(posedge clk_50MHz);
    #5;
    reset = 1'b0;
    p0 = pv_cnt;
    t0 = tick_cnt;
    drive_level(1'b1, 200);
    vec++; if (tick_cnt !== t0 + 1) begin miss++; $display("FAIL high_release_ticks: got %0d expected 1", tick_cnt - t0); end
    vec++; if (pv_cnt !== p0) begin miss++; $display("FAIL high_release_valid: got %0d pulses expected 0", pv_cnt - p0); end
  endtask

  task automatic test_reset_mid_period;
    drive_level(1'b0, 100);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk_50MHz);
      #5;
    end
    reset = 1'b0;
    p0 = pv_cnt;
    t0 = tick_cnt;
    drive_level(1'b0, 50);
    drive_level(1'b1, 10);
    vec++; if (tick_cnt !== t0 + 1) begin miss++; $display("FAIL midreset_rise_tick: got %0d expected 1", tick_cnt - t0); end
    vec++; if (pv_cnt !== p0) begin miss++; $display("FAIL midreset_rise_valid: got %0d pulses expected 0", pv_cnt - p0); end
    drive_level(1'b1, 2491);
    drive_level(1'b0, 2501);
    drive_level(1'b1, 10);
    vec++; if (pv_cnt !== p0 + 1) begin miss++; $display("FAIL midreset_next_valid: got %0d pulses expected 1", pv_cnt - p0); end
    vec++; if (last_period !== 16'd5002) begin miss++; $display("FAIL midreset_next_period: got %0d expected 5002", last_period); end
  endtask

  initial begin
    vec           = 0;
    miss          = 0;
    cyc           = 0;
    tick_cnt      = 0;
    pv_cnt        = 0;
    lost_cnt      = 0;
    last_tick_cyc = 0;
    prev_tick_cyc = 0;
    last_period   = 16'd0;
    last_in_range = 1'b0;
    reset         = 1'b1;
    bus.clk_in    = 1'b0;
    test_reset();
    test_latency();
    test_nominal();
    test_off_nominal();
    test_lost();
    test_timeout_race();
    test_reset_high_clk();
    test_reset_mid_period();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
